jtdd_adpcm_enc: RTL and testbench

- Sound-path writer counterpart to the ADPCM playback block: encodes a stream of signed 12-bit PCM samples into OKI/MSM5205 4-bit ADPCM.
- Packs the nibbles two per byte, high nibble first, and writes them into sample memory.
- Uses the same 512-byte block addressing as playback: address = {block[6:0], byte[8:0]}.
- Used for sample RAM capture and for generating ROM images that the playback path decodes bit-exactly.

---
 rtl/jtdd_adpcm_pkg.sv | 29 ++
 rtl/jtdd_adpcm_enc_core.sv | 113 +++++++++++
 rtl/jtdd_adpcm_enc.sv | 158 +++++++++++++++
 tb/tb_jtdd_adpcm_enc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_adpcm_pkg.sv
// Shared constants and types for the OKI/MSM5205 ADPCM sample writer.
package jtdd_adpcm_pkg;

  localparam int PCM_MAX = 2047;
  localparam int PCM_MIN = -2048;
  localparam int IDX_MAX = 48;

  localparam logic [10:0] STEP_TBL [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic signed [4:0] ADJ_TBL [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENC,
    ST_WRITE,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/jtdd_adpcm_enc_core.sv
// Five-cycle PCM-to-nibble ADPCM encoder; predictor and step index persist across recordings.
module jtdd_adpcm_enc_core
  import jtdd_adpcm_pkg::*;
#(
  parameter int PCM_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    accept,
  input  logic signed [PCM_W-1:0] pcm,
  input  logic                    flush_state,
  output logic [3:0]              nibble,
  output logic                    nib_valid
);

  logic signed [PCM_W-1:0] r_pred;
  logic [5:0]              r_idx;
  logic [2:0]              r_cnt;
  logic [PCM_W:0]          r_mag;
  logic                    r_sign;
  logic [2:0]              r_bits;
  logic [3:0]              r_nib;
  logic                    r_nv;

  logic signed [PCM_W:0]   w_diff;
  logic [PCM_W:0]          w_mag;
  logic [10:0]             w_step;
  logic [PCM_W:0]          w_cmp;
  logic [2:0]              w_bit;
  logic                    w_hit;
  logic [PCM_W:0]          w_delta;
  logic signed [PCM_W+1:0] w_sum;
  logic signed [PCM_W-1:0] w_pred_nx;
  logic signed [4:0]       w_adj;
  logic signed [7:0]       w_idx_sum;
  logic [5:0]              w_idx_nx;

  assign w_step = STEP_TBL[r_idx];
  assign w_diff = {pcm[PCM_W-1], pcm} - {r_pred[PCM_W-1], r_pred};
  assign w_mag  = w_diff[PCM_W] ? -w_diff : w_diff;
  assign w_hit  = r_mag >= w_cmp;

  // Serial successive approximation: step, step>>1, step>>2 -> b2, b1, b0.
  always_comb begin
    w_cmp = '0;
    w_bit = '0;
    case (r_cnt)
      3'd1: begin w_cmp = (PCM_W+1)'(w_step);      w_bit = 3'b100; end
      3'd2: begin w_cmp = (PCM_W+1)'(w_step >> 1); w_bit = 3'b010; end
      3'd3: begin w_cmp = (PCM_W+1)'(w_step >> 2); w_bit = 3'b001; end
      default: ;
    endcase
  end

  always_comb begin
    w_delta = (PCM_W+1)'(w_step >> 3);
    if (r_bits[2]) w_delta = w_delta + (PCM_W+1)'(w_step);
    if (r_bits[1]) w_delta = w_delta + (PCM_W+1)'(w_step >> 1);
    if (r_bits[0]) w_delta = w_delta + (PCM_W+1)'(w_step >> 2);
    w_sum = r_sign ? ({{2{r_pred[PCM_W-1]}}, r_pred} - {1'b0, w_delta})
                   : ({{2{r_pred[PCM_W-1]}}, r_pred} + {1'b0, w_delta});
    if (w_sum > PCM_MAX)      w_pred_nx = PCM_W'(PCM_MAX);
    else if (w_sum < PCM_MIN) w_pred_nx = PCM_W'(PCM_MIN);
    else                      w_pred_nx = w_sum[PCM_W-1:0];
  end

  always_comb begin
    w_adj     = ADJ_TBL[r_bits];
    w_idx_sum = {2'b00, r_idx} + {{3{w_adj[4]}}, w_adj};
    if (w_idx_sum < 0)             w_idx_nx = '0;
    else if (w_idx_sum > IDX_MAX)  w_idx_nx = 6'(IDX_MAX);
    else                           w_idx_nx = w_idx_sum[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_mag  <= '0;
      r_sign <= 1'b0;
      r_bits <= '0;
      r_nib  <= '0;
      r_nv   <= 1'b0;
    end else begin
      r_nv <= 1'b0;
      if (flush_state) begin
        r_cnt <= '0;
      end else if (accept && r_cnt == 3'd0) begin
        r_sign <= w_diff[PCM_W];
        r_mag  <= w_mag;
        r_bits <= '0;
        r_cnt  <= 3'd1;
      end else if (r_cnt >= 3'd1 && r_cnt <= 3'd3) begin
        if (w_hit) begin
          r_mag  <= r_mag - w_cmp;
          r_bits <= r_bits | w_bit;
        end
        r_cnt <= r_cnt + 3'd1;
      end else if (r_cnt == 3'd4) begin
        r_pred <= w_pred_nx;
        r_idx  <= w_idx_nx;
        r_nib  <= {r_sign, r_bits};
        r_nv   <= 1'b1;
        r_cnt  <= '0;
      end
    end
  end

  assign nibble    = r_nib;
  assign nib_valid = r_nv;

endmodule

// File: rtl/jtdd_adpcm_enc.sv
// ADPCM sample writer: encodes PCM, packs nibbles high-first and writes 512-byte blocks.
module jtdd_adpcm_enc
  import jtdd_adpcm_pkg::*;
#(
  parameter int PCM_W       = 12,
  parameter int NIB_PER_BLK = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [7:0]              blk_start,
  input  logic [7:0]              blk_end,
  input  logic signed [PCM_W-1:0] pcm_in,
  input  logic                    pcm_valid,
  output logic [15:0]             mem_addr,
  output logic [7:0]              mem_din,
  output logic                    mem_we,
  input  logic                    mem_ok,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam logic [8:0] BYTE_LAST = 9'(NIB_PER_BLK / 2 - 1);

  state_t     r_st;
  logic [7:0] r_blk;
  logic [7:0] r_end;
  logic [8:0] r_byte;
  logic       r_half;
  logic [3:0] r_hi;
  logic [7:0] r_din;
  logic       r_we;
  logic       r_busy;
  logic       r_done;
  logic       r_ovr;
  logic       r_stop_pend;

  logic       w_accept;
  logic       w_flush;
  logic [3:0] w_nib;
  logic       w_nib_valid;
  logic [7:0] w_blk_nx;
  logic [8:0] w_byte_nx;

  assign w_accept  = (r_st == ST_IDLE) && r_busy && pcm_valid && !stop;
  assign w_flush   = (r_st == ST_ENC) && stop;
  assign w_blk_nx  = (r_byte == BYTE_LAST) ? r_blk + 8'd1 : r_blk;
  assign w_byte_nx = (r_byte == BYTE_LAST) ? '0 : r_byte + 9'd1;

  jtdd_adpcm_enc_core #(.PCM_W(PCM_W)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept      (w_accept),
    .pcm         (pcm_in),
    .flush_state (w_flush),
    .nibble      (w_nib),
    .nib_valid   (w_nib_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= ST_IDLE;
      r_blk       <= '0;
      r_end       <= '0;
      r_byte      <= '0;
      r_half      <= 1'b0;
      r_hi        <= '0;
      r_din       <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        ST_IDLE, ST_ENC: begin
          if (r_st == ST_IDLE && !r_busy) begin
            if (start) begin
              r_blk       <= blk_start;
              r_end       <= blk_end;
              r_byte      <= '0;
              r_half      <= 1'b0;
              r_ovr       <= 1'b0;
              r_stop_pend <= 1'b0;
              if (blk_start == blk_end) r_done <= 1'b1;
              else                      r_busy <= 1'b1;
            end
          end else if (stop) begin
            // Any nibble still in the encoder is dropped; only a stored high nibble is flushed.
            if (r_half) begin
              r_din <= {r_hi, 4'h0};
              r_we  <= 1'b1;
              r_st  <= ST_FLUSH;
            end else begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_st   <= ST_IDLE;
            end
          end else if (r_st == ST_IDLE) begin
            if (w_accept) r_st <= ST_ENC;
          end else begin
            if (pcm_valid) r_ovr <= 1'b1;
            if (w_nib_valid) begin
              if (!r_half) begin
                r_hi   <= w_nib;
                r_half <= 1'b1;
                r_st   <= ST_IDLE;
              end else begin
                r_din  <= {r_hi, w_nib};
                r_half <= 1'b0;
                r_we   <= 1'b1;
                r_st   <= ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (pcm_valid) r_ovr <= 1'b1;
          // A stop during a pending write lets the byte land before finishing.
          if (stop) r_stop_pend <= 1'b1;
          if (r_we && mem_ok) begin
            r_we   <= 1'b0;
            r_byte <= w_byte_nx;
            r_blk  <= w_blk_nx;
            if (w_blk_nx == r_end || r_stop_pend || stop) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
            r_st <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (r_we && mem_ok) begin
            r_we   <= 1'b0;
            r_byte <= w_byte_nx;
            r_blk  <= w_blk_nx;
            r_half <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_st   <= ST_IDLE;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr = {r_blk[6:0], r_byte};
  assign mem_din  = r_din;
  assign mem_we   = r_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_ovr;

endmodule

// File: tb/tb_jtdd_adpcm_enc.sv
// Directed bench for jtdd_adpcm_enc with an arithmetic reference model of the OKI encoder.
module tb_jtdd_adpcm_enc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, pcm_valid, mem_ok;
  logic [7:0]         blk_start, blk_end;
  logic signed [11:0] pcm_in;
  logic [15:0]        mem_addr;
  logic [7:0]         mem_din;
  logic               mem_we, busy, done, overrun;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  int          m_pred, m_idx;
  logic [3:0]  exp_nib[$];
  logic [23:0] got_w[$];

  int STEPS[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                    107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,
                    449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
  int ADJS[8]  = '{-1,-1,-1,-1,2,4,6,8};

  always #5 clk = ~clk;

  jtdd_adpcm_enc #(.PCM_W(12), .NIB_PER_BLK(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .blk_start (blk_start),
    .blk_end   (blk_end),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_ok    (mem_ok),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    if (mem_we && mem_ok) got_w.push_back({mem_addr, mem_din});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_enc(input int x, output logic [3:0] nib);
    int step, diff, mag, code, delta;
    step = STEPS[m_idx];
    diff = x - m_pred;
    code = 0;
    if (diff < 0) begin code = 8; mag = -diff; end
    else mag = diff;
    if (mag >= step)     begin code += 4; mag -= step;     end
    if (mag >= step / 2) begin code += 2; mag -= step / 2; end
    if (mag >= step / 4) code += 1;
    delta = step / 8;
    if (code & 4) delta += step;
    if (code & 2) delta += step / 2;
    if (code & 1) delta += step / 4;
    m_pred = (code & 8) ? m_pred - delta : m_pred + delta;
    if (m_pred > 2047)  m_pred = 2047;
    if (m_pred < -2048) m_pred = -2048;
    m_idx += ADJS[code & 7];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 48) m_idx = 48;
    nib = 4'(code);
  endtask

  task automatic send_sample(input int x, input bit use_model);
    logic [3:0] n;
    @(posedge clk); #1;
    pcm_in    = 12'(x);
    pcm_valid = 1'b1;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    if (use_model) begin
      model_enc(x, n);
      exp_nib.push_back(n);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] bs, input logic [7:0] be);
    @(posedge clk); #1;
    blk_start = bs;
    blk_end   = be;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic check_writes(input int blk0, input int base, input string tag);
    int nb;
    nb = (exp_nib.size() + 1) / 2;
    check({tag, " count"}, 32'(got_w.size() - base), 32'(nb));
    for (int k = 0; k < nb && base + k < got_w.size(); k++) begin
      logic [7:0]  b;
      logic [15:0] a;
      b = {exp_nib[2*k], (2*k + 1 < exp_nib.size()) ? exp_nib[2*k+1] : 4'h0};
      a = 16'((((blk0 + k / 512) & 127) * 512) + (k % 512));
      check(tag, 32'(got_w[base+k]), {8'h0, a, b});
    end
    exp_nib.delete();
  endtask

  initial begin
    int base, d0;
    logic [7:0] eb;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pcm_valid = 1'b0; mem_ok = 1'b1;
    blk_start = '0; blk_end = '0; pcm_in = '0;
    m_pred = 0; m_idx = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_din", 32'(mem_din), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst overrun", 32'(overrun), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic encode: 0 then 100 from reset predictor
    base = got_w.size(); d0 = done_cnt;
    pulse_start(8'd3, 8'd4);
    check("t1 busy", 32'(busy), 1);
    send_sample(0, 1'b1);
    send_sample(100, 1'b1);
    check("t1 first write", (got_w.size() > base) ? 32'(got_w[base]) : 32'hFFFF_FFFF, 32'h0006_0007);
    pulse_stop();
    repeat (3) @(posedge clk);
    check_writes(3, base, "t1 write");
    check("t1 done", 32'(done_cnt - d0), 1);
    check("t1 busy end", 32'(busy), 0);

    // two full blocks, ends by itself at blk 7
    base = got_w.size(); d0 = done_cnt;
    pulse_start(8'd5, 8'd7);
    for (int i = 0; i < 2048; i++) send_sample(((i * 97) % 4096) - 2048, 1'b1);
    repeat (4) @(posedge clk);
    check("t2 last addr", (got_w.size() == base + 1024) ? 32'(got_w[base+1023][23:8]) : 32'hFFFF_FFFF, 32'h0DFF);
    check_writes(5, base, "t2 write");
    check("t2 done", 32'(done_cnt - d0), 1);
    check("t2 busy end", 32'(busy), 0);

    // handshake stall with overrun
    mem_ok = 1'b0;
    base = got_w.size(); d0 = done_cnt;
    pulse_start(8'd1, 8'd2);
    send_sample(-700, 1'b1);
    send_sample(1500, 1'b1);
    eb = {exp_nib[0], exp_nib[1]};
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 pcm_valid = (c == 10);
      @(negedge clk);
      check("t3 stall we", 32'(mem_we), 1);
      check("t3 stall addr", 32'(mem_addr), 32'h0200);
      check("t3 stall din", 32'(mem_din), 32'(eb));
    end
    @(posedge clk); #1 pcm_valid = 1'b0;
    check("t3 overrun", 32'(overrun), 1);
    mem_ok = 1'b1;
    repeat (3) @(posedge clk);
    pulse_stop();
    repeat (3) @(posedge clk);
    check_writes(1, base, "t3 write");
    check("t3 done", 32'(done_cnt - d0), 1);

    // degenerate start also clears overrun
    base = got_w.size(); d0 = done_cnt;
    pulse_start(8'd9, 8'd9);
    check("t4 done now", 32'(done), 1);
    check("t4 overrun clr", 32'(overrun), 0);
    check("t4 busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    check("t4 done cnt", 32'(done_cnt - d0), 1);
    check("t4 no writes", 32'(got_w.size() - base), 0);

    // stop with an odd nibble pending
    base = got_w.size(); d0 = done_cnt;
    pulse_start(8'd0, 8'd1);
    send_sample(300, 1'b1);
    send_sample(-50, 1'b1);
    send_sample(900, 1'b1);
    pulse_stop();
    repeat (4) @(posedge clk);
    check_writes(0, base, "t5 write");
    check("t5 done", 32'(done_cnt - d0), 1);
    check("t5 busy", 32'(busy), 0);

    // saturation of predictor and index
    base = got_w.size(); d0 = done_cnt;
    pulse_start(8'd20, 8'd21);
    for (int i = 0; i < 300; i++) send_sample(-2048, 1'b1);
    for (int i = 0; i < 300; i++) send_sample(2047, 1'b1);
    pulse_stop();
    repeat (4) @(posedge clk);
    check_writes(20, base, "t6 write");
    check("t6 done", 32'(done_cnt - d0), 1);
    check("t6 busy", 32'(busy), 0);

    // reset while a write is pending
    mem_ok = 1'b0;
    pulse_start(8'd30, 8'd31);
    send_sample(10, 1'b1);
    send_sample(20, 1'b1);
    @(posedge clk); #1 pcm_valid = 1'b1;
    @(posedge clk); #1 pcm_valid = 1'b0;
    @(negedge clk);
    check("t7 we before", 32'(mem_we), 1);
    check("t7 ovr before", 32'(overrun), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7 rst we", 32'(mem_we), 0);
    check("t7 rst addr", 32'(mem_addr), 0);
    check("t7 rst din", 32'(mem_din), 0);
    check("t7 rst busy", 32'(busy), 0);
    check("t7 rst done", 32'(done), 0);
    check("t7 rst overrun", 32'(overrun), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
